// File: rtl/sparhixcel_pkg.sv
// Shared definitions for the feature/weight feed engine: default widths, FSM encodings
// and the skid depth needed to absorb a full memory read pipeline.
package sparhixcel_pkg;

    localparam int DEF_N_ROWS_ARRAY    = 9;
    localparam int DEF_I_WIDTH         = 8;
    localparam int DEF_F_WIDTH         = 8;
    localparam int DEF_FEAT_ADDR_WIDTH = 16;
    localparam int DEF_W_ADDR_WIDTH    = 10;
    localparam int DEF_ROUND_WIDTH     = 3;
    localparam int DEF_MEM_RD_LATENCY  = 1;

    typedef logic [2:0] feed_state_e;

    localparam feed_state_e ST_IDLE   = 3'd0;
    localparam feed_state_e ST_LOAD_W = 3'd1;
    localparam feed_state_e ST_STREAM = 3'd2;
    localparam feed_state_e ST_SWAP   = 3'd3;
    localparam feed_state_e ST_DRAIN  = 3'd4;

    // One slot per in-flight read plus one for the word waiting on the array.
    function automatic int skid_depth(input int mem_rd_latency);
        return mem_rd_latency + 1;
    endfunction

endpackage

// File: rtl/sparhixcel_skid_fifo.sv
// Small FIFO holding feature words returned by memory until the array accepts them.
// Head is presented combinationally and forced to zero while the FIFO is empty.
module sparhixcel_skid_fifo
    import sparhixcel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign valid_o = (count_reg != '0);
    assign do_pop  = pop_i && valid_o;
    assign head_o  = valid_o ? mem_reg[rd_ptr_reg] : '0;
    assign count_o = count_reg;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_i, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sparhixcel_feed_engine.sv
// Feeds the systolic array: sweeps the feature address range once per weight round,
// double-buffers the weight word and skid-buffers returning feature words.
module sparhixcel_feed_engine
    import sparhixcel_pkg::*;
#(
    parameter int N_ROWS_ARRAY    = DEF_N_ROWS_ARRAY,
    parameter int I_WIDTH         = DEF_I_WIDTH,
    parameter int F_WIDTH         = DEF_F_WIDTH,
    parameter int FEAT_ADDR_WIDTH = DEF_FEAT_ADDR_WIDTH,
    parameter int W_ADDR_WIDTH    = DEF_W_ADDR_WIDTH,
    parameter int ROUND_WIDTH     = DEF_ROUND_WIDTH,
    parameter int MEM_RD_LATENCY  = DEF_MEM_RD_LATENCY
) (
    input  logic                              clk_i,
    input  logic                              general_rst_ni,
    input  logic                              start_i,
    input  logic [FEAT_ADDR_WIDTH-1:0]        start_addr_feature_i,
    input  logic [FEAT_ADDR_WIDTH-1:0]        end_addr_feature_i,
    input  logic [W_ADDR_WIDTH-1:0]           weight_base_addr_i,
    input  logic [ROUND_WIDTH-1:0]            n_round_weight_i,
    output logic                              feat_rd_en_o,
    output logic [FEAT_ADDR_WIDTH-1:0]        feat_addr_o,
    input  logic [N_ROWS_ARRAY*I_WIDTH-1:0]   feat_data_i,
    output logic                              w_rd_en_o,
    output logic [W_ADDR_WIDTH-1:0]           w_addr_o,
    input  logic [N_ROWS_ARRAY*F_WIDTH-1:0]   w_data_i,
    output logic [N_ROWS_ARRAY*I_WIDTH-1:0]   in_feature_o,
    output logic                              in_feature_valid_o,
    input  logic                              array_ready_i,
    output logic [N_ROWS_ARRAY*F_WIDTH-1:0]   f_weight_o,
    output logic                              weight_swap_o,
    output logic [ROUND_WIDTH-1:0]            round_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              config_err_o
);

    localparam int SKID_DEPTH = skid_depth(MEM_RD_LATENCY);
    localparam int FEAT_W     = N_ROWS_ARRAY * I_WIDTH;
    localparam int WGT_W      = N_ROWS_ARRAY * F_WIDTH;
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

    feed_state_e                 state_reg, state_next;
    logic [FEAT_ADDR_WIDTH-1:0]  start_addr_reg, end_addr_reg;
    logic [FEAT_ADDR_WIDTH-1:0]  feat_addr_reg, pop_addr_reg;
    logic [W_ADDR_WIDTH-1:0]     base_reg;
    logic [ROUND_WIDTH-1:0]      n_round_reg, round_reg;
    logic                        issue_done_reg;
    logic [WGT_W-1:0]            active_reg, shadow_reg;
    logic                        shadow_valid_reg, swap_reg, err_reg;
    logic [MEM_RD_LATENCY-1:0]   feat_pipe_reg, feat_pipe_next;
    logic [MEM_RD_LATENCY-1:0]   w_pipe_reg, w_pipe_next;

    logic                        cfg_ok, start_ok, feat_ret, w_ret;
    logic                        fifo_valid, pop, last_pop, more_rounds, swap_go, feat_issue;
    logic [FEAT_W-1:0]           fifo_head;
    logic [CNT_W-1:0]            fifo_count;
    logic [ROUND_WIDTH:0]        round_p1, round_p2, n_ext;
    logic                        w_rd_next;
    logic [W_ADDR_WIDTH-1:0]     w_addr_next;
    int                          occ;

    assign cfg_ok      = (n_round_weight_i != '0) && (end_addr_feature_i >= start_addr_feature_i);
    assign start_ok    = general_rst_ni && (state_reg == ST_IDLE) && start_i && cfg_ok;
    assign feat_ret    = feat_pipe_reg[MEM_RD_LATENCY-1];
    assign w_ret       = w_pipe_reg[MEM_RD_LATENCY-1];
    assign pop         = fifo_valid && array_ready_i;
    assign last_pop    = pop && (pop_addr_reg == end_addr_reg);
    assign round_p1    = {1'b0, round_reg} + (ROUND_WIDTH+1)'(1);
    assign round_p2    = {1'b0, round_reg} + (ROUND_WIDTH+1)'(2);
    assign n_ext       = {1'b0, n_round_reg};
    assign more_rounds = round_p1 < n_ext;
    assign swap_go     = (state_reg == ST_SWAP) && shadow_valid_reg;

    // Count the word being popped this cycle as already gone so a full-rate stream never stalls.
    assign occ        = int'(fifo_count) + $countones(feat_pipe_reg) - int'(pop);
    assign feat_issue = (state_reg == ST_STREAM) && !issue_done_reg && (occ < SKID_DEPTH);

    always_comb begin
        w_rd_next   = 1'b0;
        w_addr_next = '0;
        case (state_reg)
            ST_IDLE: if (start_ok) begin
                w_rd_next   = 1'b1;
                w_addr_next = weight_base_addr_i;
            end
            ST_LOAD_W: if (w_ret && (n_round_reg > ROUND_WIDTH'(1))) begin
                w_rd_next   = 1'b1;
                w_addr_next = base_reg + W_ADDR_WIDTH'(1);
            end
            ST_SWAP: if (swap_go && (round_p2 < n_ext)) begin
                w_rd_next   = 1'b1;
                w_addr_next = base_reg + W_ADDR_WIDTH'(round_p2);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start_ok) state_next = ST_LOAD_W;
            ST_LOAD_W: if (w_ret) state_next = ST_STREAM;
            ST_STREAM: if (last_pop) state_next = more_rounds ? ST_SWAP : ST_DRAIN;
            ST_SWAP:   if (shadow_valid_reg) state_next = ST_STREAM;
            ST_DRAIN:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < MEM_RD_LATENCY; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_head
                assign feat_pipe_next[gi] = feat_issue;
                assign w_pipe_next[gi]    = w_rd_next;
            end else begin : g_tail
                assign feat_pipe_next[gi] = feat_pipe_reg[gi-1];
                assign w_pipe_next[gi]    = w_pipe_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!general_rst_ni) begin
            state_reg        <= ST_IDLE;
            start_addr_reg   <= '0;
            end_addr_reg     <= '0;
            feat_addr_reg    <= '0;
            pop_addr_reg     <= '0;
            base_reg         <= '0;
            n_round_reg      <= '0;
            round_reg        <= '0;
            issue_done_reg   <= 1'b0;
            active_reg       <= '0;
            shadow_reg       <= '0;
            shadow_valid_reg <= 1'b0;
            swap_reg         <= 1'b0;
            err_reg          <= 1'b0;
            feat_pipe_reg    <= '0;
            w_pipe_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            feat_pipe_reg <= feat_pipe_next;
            w_pipe_reg    <= w_pipe_next;
            swap_reg      <= swap_go;
            err_reg       <= (state_reg == ST_IDLE) && start_i && !cfg_ok;
            if (start_ok) begin
                start_addr_reg   <= start_addr_feature_i;
                end_addr_reg     <= end_addr_feature_i;
                base_reg         <= weight_base_addr_i;
                n_round_reg      <= n_round_weight_i;
                round_reg        <= '0;
                feat_addr_reg    <= start_addr_feature_i;
                pop_addr_reg     <= start_addr_feature_i;
                issue_done_reg   <= 1'b0;
                shadow_valid_reg <= 1'b0;
            end
            // The only read outstanding in LOAD_W is round 0; every later return is a prefetch.
            if (w_ret && (state_reg == ST_LOAD_W)) begin
                active_reg <= w_data_i;
            end else if (w_ret) begin
                shadow_reg       <= w_data_i;
                shadow_valid_reg <= 1'b1;
            end
            if (feat_issue) begin
                if (feat_addr_reg == end_addr_reg) begin
                    issue_done_reg <= 1'b1;
                end else begin
                    feat_addr_reg <= feat_addr_reg + FEAT_ADDR_WIDTH'(1);
                end
            end
            if (pop) begin
                pop_addr_reg <= pop_addr_reg + FEAT_ADDR_WIDTH'(1);
            end
            if (swap_go) begin
                active_reg       <= shadow_reg;
                shadow_valid_reg <= 1'b0;
                round_reg        <= round_reg + ROUND_WIDTH'(1);
                feat_addr_reg    <= start_addr_reg;
                pop_addr_reg     <= start_addr_reg;
                issue_done_reg   <= 1'b0;
            end
        end
    end

    sparhixcel_skid_fifo #(
        .WIDTH (FEAT_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid_fifo (
        .clk_i       (clk_i),
        .rst_ni      (general_rst_ni),
        .push_i      (feat_ret),
        .push_data_i (feat_data_i),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign feat_rd_en_o       = feat_issue;
    assign feat_addr_o        = feat_issue ? feat_addr_reg : '0;
    assign w_rd_en_o          = w_rd_next;
    assign w_addr_o           = w_addr_next;
    assign in_feature_o       = fifo_head;
    assign in_feature_valid_o = fifo_valid;
    assign f_weight_o         = active_reg;
    assign weight_swap_o      = swap_reg;
    assign round_o            = round_reg;
    assign busy_o             = (state_reg != ST_IDLE) && (state_reg != ST_DRAIN);
    assign done_o             = (state_reg == ST_DRAIN);
    assign config_err_o       = err_reg;

endmodule

// File: tb/tb_sparhixcel_feed_engine.sv
// Scoreboard bench for the feed engine with 3-cycle memory models: expected addresses and
// array words are queued at stimulus time and popped by a negedge monitor.
module tb_sparhixcel_feed_engine;

    localparam int LAT = 3;
    localparam int NR  = 9;
    localparam int IW  = 8;
    localparam int FW  = 8;
    localparam int FAW = 16;
    localparam int WAW = 10;
    localparam int RW  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [FAW-1:0]    start_addr, end_addr;
    logic [WAW-1:0]    base_addr;
    logic [RW-1:0]     n_round;
    logic              feat_rd_en;
    logic [FAW-1:0]    feat_addr;
    logic [NR*IW-1:0]  feat_data;
    logic              w_rd_en;
    logic [WAW-1:0]    w_addr;
    logic [NR*FW-1:0]  w_data;
    logic [NR*IW-1:0]  in_feature;
    logic              in_feature_valid;
    logic              array_ready = 1'b1;
    logic [NR*FW-1:0]  f_weight;
    logic              weight_swap;
    logic [RW-1:0]     round;
    logic              busy, done, config_err;

    int checks   = 0;
    int failures = 0;
    int swaps    = 0;
    int dones    = 0;
    int errs     = 0;
    int ready_mode = 0;
    logic mon_en = 1'b0;

    logic [NR*IW-1:0] exp_word_q [$];
    logic [NR*FW-1:0] exp_wgt_q [$];
    logic [RW-1:0]    exp_round_q [$];
    logic [FAW-1:0]   exp_faddr_q [$];
    logic [WAW-1:0]   exp_waddr_q [$];

    always #5 clk = ~clk;

    sparhixcel_feed_engine #(
        .MEM_RD_LATENCY (LAT)
    ) dut (
        .clk_i                (clk),
        .general_rst_ni       (rst_n),
        .start_i              (start_i),
        .start_addr_feature_i (start_addr),
        .end_addr_feature_i   (end_addr),
        .weight_base_addr_i   (base_addr),
        .n_round_weight_i     (n_round),
        .feat_rd_en_o         (feat_rd_en),
        .feat_addr_o          (feat_addr),
        .feat_data_i          (feat_data),
        .w_rd_en_o            (w_rd_en),
        .w_addr_o             (w_addr),
        .w_data_i             (w_data),
        .in_feature_o         (in_feature),
        .in_feature_valid_o   (in_feature_valid),
        .array_ready_i        (array_ready),
        .f_weight_o           (f_weight),
        .weight_swap_o        (weight_swap),
        .round_o              (round),
        .busy_o               (busy),
        .done_o               (done),
        .config_err_o         (config_err)
    );

    function automatic logic [NR*IW-1:0] feat_word(input logic [FAW-1:0] a);
        logic [NR*IW-1:0] w;
        for (int l = 0; l < NR; l++) w[l*IW +: IW] = (a[7:0] ^ a[15:8]) + 8'(l * 29);
        return w;
    endfunction

    function automatic logic [NR*FW-1:0] w_word(input logic [WAW-1:0] a);
        logic [NR*FW-1:0] w;
        for (int l = 0; l < NR; l++) w[l*FW +: FW] = (a[7:0] * 8'd3) + 8'(l) + 8'h40;
        return w;
    endfunction

    // Memory models: fixed LAT-cycle read pipelines, never reset, so late data keeps arriving.
    logic [FAW-1:0] fa_pipe [LAT];
    logic           fv_pipe [LAT];
    logic [WAW-1:0] wa_pipe [LAT];
    always @(posedge clk) begin
        fa_pipe[0] <= feat_addr;
        fv_pipe[0] <= feat_rd_en;
        wa_pipe[0] <= w_addr;
        for (int i = 1; i < LAT; i++) begin
            fa_pipe[i] <= fa_pipe[i-1];
            fv_pipe[i] <= fv_pipe[i-1];
            wa_pipe[i] <= wa_pipe[i-1];
        end
    end
    assign feat_data = feat_word(fa_pipe[LAT-1]);
    assign w_data    = w_word(wa_pipe[LAT-1]);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes a read or hands a word to the array.
    always @(negedge clk) begin
        if (mon_en) begin
            if (feat_rd_en) begin
                if (exp_faddr_q.size() == 0) check("feat_rd_en_unexpected", 128'(feat_rd_en), 0);
                else check("feat_addr", 128'(feat_addr), 128'(exp_faddr_q.pop_front()));
            end
            if (w_rd_en) begin
                if (exp_waddr_q.size() == 0) check("w_rd_en_unexpected", 128'(w_rd_en), 0);
                else check("w_addr", 128'(w_addr), 128'(exp_waddr_q.pop_front()));
            end
            if (in_feature_valid && array_ready) begin
                if (exp_word_q.size() == 0) begin
                    check("word_unexpected", 128'(in_feature_valid), 0);
                end else begin
                    check("in_feature", 128'(in_feature), 128'(exp_word_q.pop_front()));
                    check("f_weight", 128'(f_weight), 128'(exp_wgt_q.pop_front()));
                    check("round", 128'(round), 128'(exp_round_q.pop_front()));
                end
            end
            if (weight_swap) swaps++;
            if (done) dones++;
            if (config_err) errs++;
        end
    end

    // Array back-pressure: 0 = always ready, 1 = toggling, otherwise stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       array_ready = 1'b1;
                1:       array_ready = ~array_ready;
                default: array_ready = 1'b0;
            endcase
        end
    end

    task automatic push_expect(input int s, input int e, input int b, input int n);
        for (int r = 0; r < n; r++) begin
            exp_waddr_q.push_back(WAW'(b + r));
            for (int a = s; a <= e; a++) begin
                exp_faddr_q.push_back(FAW'(a));
                exp_word_q.push_back(feat_word(FAW'(a)));
                exp_wgt_q.push_back(w_word(WAW'(b + r)));
                exp_round_q.push_back(RW'(r));
            end
        end
    endtask

    task automatic start_run(input int s, input int e, input int b, input int n);
        @(posedge clk);
        #1;
        start_addr = FAW'(s);
        end_addr   = FAW'(e);
        base_addr  = WAW'(b);
        n_round    = RW'(n);
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = dones;
        int n  = 0;
        while (dones == d0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_pulse"}, 128'(dones - d0), 1);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_single_done"}, 128'(dones - d0), 1);
        check({name, "_busy_after"}, 128'(busy), 0);
        check({name, "_words_left"}, 128'(exp_word_q.size()), 0);
        check({name, "_faddr_left"}, 128'(exp_faddr_q.size()), 0);
        check({name, "_waddr_left"}, 128'(exp_waddr_q.size()), 0);
    endtask

    task automatic reset_checks(input string p);
        check({p, "_busy"}, 128'(busy), 0);
        check({p, "_done"}, 128'(done), 0);
        check({p, "_err"}, 128'(config_err), 0);
        check({p, "_feat_rd_en"}, 128'(feat_rd_en), 0);
        check({p, "_feat_addr"}, 128'(feat_addr), 0);
        check({p, "_w_rd_en"}, 128'(w_rd_en), 0);
        check({p, "_w_addr"}, 128'(w_addr), 0);
        check({p, "_valid"}, 128'(in_feature_valid), 0);
        check({p, "_in_feature"}, 128'(in_feature), 0);
        check({p, "_f_weight"}, 128'(f_weight), 0);
        check({p, "_swap"}, 128'(weight_swap), 0);
        check({p, "_round"}, 128'(round), 0);
    endtask

    initial begin
        int s0, e0, n, busy_seen, valid_seen;
        rst_n = 1'b0; start_i = 1'b0;
        start_addr = '0; end_addr = '0; base_addr = '0; n_round = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Two rounds, full-rate array
        s0 = swaps; push_expect(0, 3, 5, 2); start_run(0, 3, 5, 2);
        wait_done("two_round", 300);
        check("two_round_swaps", 128'(swaps - s0), 1);

        // Same run with toggling ready
        ready_mode = 1;
        s0 = swaps; push_expect(0, 3, 5, 2); start_run(0, 3, 5, 2);
        wait_done("toggle_ready", 400);
        check("toggle_ready_swaps", 128'(swaps - s0), 1);

        // Single-word sweep, three rounds
        ready_mode = 0;
        s0 = swaps; push_expect(7, 7, 20, 3); start_run(7, 7, 20, 3);
        wait_done("one_word", 300);
        check("one_word_swaps", 128'(swaps - s0), 2);

        // Sweep ending at the top of the address space
        s0 = swaps; push_expect(16'hFFFE, 16'hFFFF, 40, 1); start_run(16'hFFFE, 16'hFFFF, 40, 1);
        wait_done("addr_top", 300);
        check("addr_top_swaps", 128'(swaps - s0), 0);

        // Illegal configurations: zero rounds, end before start
        e0 = errs; busy_seen = 0;
        start_run(0, 3, 5, 0);
        repeat (8) begin @(posedge clk); #1; busy_seen += int'(busy); end
        check("zero_round_err", 128'(errs - e0), 1);
        check("zero_round_busy", 128'(busy_seen), 0);
        e0 = errs; busy_seen = 0;
        start_run(5, 4, 5, 1);
        repeat (8) begin @(posedge clk); #1; busy_seen += int'(busy); end
        check("end_lt_start_err", 128'(errs - e0), 1);
        check("end_lt_start_busy", 128'(busy_seen), 0);

        // Start pulse with a different config while busy
        s0 = swaps; e0 = errs;
        push_expect(2, 5, 8, 2); start_run(2, 5, 8, 2);
        repeat (4) @(posedge clk);
        start_run(10, 12, 30, 1);
        wait_done("start_busy", 400);
        check("start_busy_swaps", 128'(swaps - s0), 1);
        check("start_busy_err", 128'(errs - e0), 0);

        // Reset while reads are in flight
        ready_mode = 2;
        push_expect(0, 20, 50, 1); start_run(0, 20, 50, 1);
        n = 0;
        while ((int'(fv_pipe[0]) + int'(fv_pipe[1]) + int'(fv_pipe[2])) < 2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("inflight_reached", 128'(n < 100), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_word_q.delete(); exp_wgt_q.delete(); exp_round_q.delete();
        exp_faddr_q.delete(); exp_waddr_q.delete();
        @(negedge clk);
        reset_checks("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_mode = 0;
        valid_seen = 0;
        repeat (6) begin @(negedge clk); valid_seen += int'(in_feature_valid); end
        check("late_data_dropped", 128'(valid_seen), 0);

        // Recovery after reset
        push_expect(1, 2, 3, 1); start_run(1, 2, 3, 1);
        wait_done("recover", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
